// File: rtl/serial_pkg.sv
// serial_pkg: shared widths, state encoding, idle level and 7-segment table for serial_frame_tx.
package serial_pkg;
    localparam int PORT_W = 2;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 16;
    localparam logic IDLE_LVL = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_LEN,
        S_DATA,
        S_PARITY,
        S_DONE
    } state_e;
    // Active-high segments, bit order gfedcba.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [6:0] hex_to_seg(input logic [LEN_W-1:0] v);
        return SEG_HEX[v];
    endfunction
endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: request fields and serial line/status outputs of serial_frame_tx.
interface serial_frame_tx_if;
    import serial_pkg::*;
    logic              clkEn;
    logic              start;
    logic [PORT_W-1:0] portSel;
    logic [LEN_W-1:0]  dataLen;
    logic [DATA_W-1:0] dataIn;
    logic              SerOut;
    logic              Busy;
    logic              Done;
    logic [6:0]        SSD_Out;
    modport master (
        output clkEn, start, portSel, dataLen, dataIn,
        input  SerOut, Busy, Done, SSD_Out
    );
    modport slave (
        input  clkEn, start, portSel, dataLen, dataIn,
        output SerOut, Busy, Done, SSD_Out
    );
endinterface

// File: rtl/bit_counter.sv
// bit_counter: loadable down-counter that saturates at zero and flags it.
module bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero = (cnt_q == '0);
    assign cnt  = cnt_q;
    always_comb cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - W'(1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter (start, port, length, data, done); outputs are
// registered from the current state. Define TX_PARITY_EN to append an even-parity bit.
module serial_frame_tx
    import serial_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    serial_frame_tx_if.slave bus
);
    state_e            state_q, state_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              ser_q, ser_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [6:0]        ssd_q, ssd_d;
    logic              cnt_load;
    logic [LEN_W-1:0]  cnt_val, cnt;
    logic              cnt_zero;
    logic              bit_cur;
`ifdef TX_PARITY_EN
    logic              par_q, par_d;
    localparam state_e AFTER_DATA = S_PARITY;
`else
    localparam state_e AFTER_DATA = S_DONE;
`endif

    // Counter holds the number of bits still to send after the current one.
    bit_counter #(.W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.clkEn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        len_d    = len_q;
        sh_d     = sh_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        bit_cur  = IDLE_LVL;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_START;
                port_d  = bus.portSel;
                len_d   = bus.dataLen;
                sh_d    = bus.dataIn;
            end
            S_START: begin
                bit_cur  = 1'b0;
                state_d  = S_PORT;
                cnt_load = 1'b1;
                cnt_val  = LEN_W'(PORT_W - 1);
            end
            S_PORT: begin
                bit_cur = port_q[cnt[0]];
                if (cnt_zero) begin
                    state_d  = S_LEN;
                    cnt_load = 1'b1;
                    cnt_val  = LEN_W'(LEN_W - 1);
                end
            end
            S_LEN: begin
                bit_cur = len_q[cnt[1:0]];
                if (cnt_zero) begin
                    state_d  = (len_q != '0) ? S_DATA : AFTER_DATA;
                    cnt_load = (len_q != '0);
                    cnt_val  = len_q - LEN_W'(1);
                end
            end
            S_DATA: begin
                bit_cur = sh_q[0];
                sh_d    = sh_q >> 1;
                if (cnt_zero)
                    state_d = AFTER_DATA;
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                bit_cur = par_q;
                state_d = S_DONE;
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ser_d  = bit_cur;
        busy_d = (state_q != S_IDLE);
        done_d = (state_q == S_DONE);
        ssd_d  = hex_to_seg((state_q == S_DATA) ? cnt + LEN_W'(1) : '0);
    end

`ifdef TX_PARITY_EN
    always_comb par_d = (state_q inside {S_PORT, S_LEN, S_DATA}) ? par_q ^ bit_cur :
                        (state_q == S_IDLE) ? 1'b0 : par_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            par_q <= 1'b0;
        else if (bus.clkEn)
            par_q <= par_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            port_q  <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            ser_q   <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ssd_q   <= hex_to_seg('0);
        end else if (bus.clkEn) begin
            state_q <= state_d;
            port_q  <= port_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ssd_q   <= ssd_d;
        end
    end

    assign bus.SerOut  = ser_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.SSD_Out = ssd_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench; a frame-level model queues the expected line states per bit period.
module tb_serial_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    serial_frame_tx_if bus();
    serial_frame_tx dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ser;
        logic       busy;
        logic       done;
        logic [6:0] ssd;
    } rec_t;
    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam rec_t IDLE_REC = '{ser: 1'b1, busy: 1'b0, done: 1'b0, ssd: 7'h3F};

    rec_t q[$];
    rec_t cur = IDLE_REC;
    int   busy_left = 0;
    int   accepts = 0;
    bit   upd = 0;
    int   tests = 0;
    int   fails = 0;
    int   en_div = 1;
    int   ph = 0;

    function automatic rec_t mk(logic s, logic b, logic d, logic [6:0] g);
        rec_t r;
        r.ser = s; r.busy = b; r.done = d; r.ssd = g;
        return r;
    endfunction

    // One output period of idle precedes each frame's start bit, then the frame, then Done.
    function automatic int push_frame(logic [1:0] p, logic [3:0] l, logic [15:0] d);
        logic par;
        int   n;
        par = ^p ^ ^l;
        q.push_back(IDLE_REC);
        q.push_back(mk(1'b0, 1'b1, 1'b0, SEG[0]));
        for (int i = 1; i >= 0; i--) q.push_back(mk(p[i], 1'b1, 1'b0, SEG[0]));
        for (int i = 3; i >= 0; i--) q.push_back(mk(l[i], 1'b1, 1'b0, SEG[0]));
        for (int i = 0; i < int'(l); i++) begin
            q.push_back(mk(d[i], 1'b1, 1'b0, SEG[int'(l) - i]));
            par ^= d[i];
        end
        n = 8 + int'(l);
`ifdef TX_PARITY_EN
        q.push_back(mk(par, 1'b1, 1'b0, SEG[0]));
        n++;
`endif
        q.push_back(mk(1'b1, 1'b1, 1'b1, SEG[0]));
        return n;
    endfunction

    function automatic void check(string nm, rec_t got, rec_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got ser=%b busy=%b done=%b ssd=%h expected ser=%b busy=%b done=%b ssd=%h",
                     nm, $time, got.ser, got.busy, got.done, got.ssd, exp.ser, exp.busy, exp.done, exp.ssd);
        end
    endfunction

    function automatic void timeout(string nm);
        tests++;
        fails++;
        $display("FAIL timeout %s t=%0t got no event expected one", nm, $time);
    endfunction

    // Reference model: acceptance in idle on an enabled edge, each frame state lasts one enabled edge.
    always @(posedge clk) begin
        upd = rst && bus.clkEn;
        if (!rst)
            busy_left = 0;
        else if (bus.clkEn) begin
            if (busy_left == 0 && bus.start) begin
                busy_left = push_frame(bus.portSel, bus.dataLen, bus.dataIn);
                accepts++;
            end else if (busy_left > 0)
                busy_left--;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            cur = IDLE_REC;
        end else if (upd)
            cur = (q.size() > 0) ? q.pop_front() : IDLE_REC;
        check("line", {bus.SerOut, bus.Busy, bus.Done, bus.SSD_Out}, cur);
    end

    initial begin
        bus.clkEn = 1'b0;
        forever begin
            @(negedge clk);
            if (en_div == 0)
                bus.clkEn = 1'($urandom_range(0, 1));
            else begin
                ph = (ph + 1) % en_div;
                bus.clkEn = (ph == 0);
            end
        end
    end

    task automatic wait_en();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(bus.clkEn && rst) && n < 200);
        if (n >= 200) timeout("clkEn");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_left != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout("idle");
    endtask

    task automatic scramble();
        bus.portSel = 2'($urandom);
        bus.dataLen = 4'($urandom);
        bus.dataIn  = 16'($urandom);
    endtask

    task automatic send(logic [1:0] p, logic [3:0] l, logic [15:0] d);
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.portSel = p;
        bus.dataLen = l;
        bus.dataIn = d;
        wait_en();
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
    endtask

    initial begin
        int base;
        int n;
        bus.start = 1'b0;
        bus.portSel = '0;
        bus.dataLen = '0;
        bus.dataIn = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(2'b10, 4'd3, 16'h0005);
        send(2'b11, 4'd0, 16'($urandom));
        send(2'b01, 4'd2, 16'h0003);
        send(2'b10, 4'd15, 16'($urandom));
        en_div = 4;
        send(2'b10, 4'd3, 16'h0005);
        en_div = 0;
        for (int i = 0; i < 8; i++) send(2'($urandom), 4'($urandom), 16'($urandom));
        en_div = 1;
        // Asynchronous reset while data bit 2 is on the line.
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.portSel = 2'($urandom);
        bus.dataLen = 4'd5;
        bus.dataIn = 16'($urandom);
        wait_en();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_async", {bus.SerOut, bus.Busy, bus.Done, bus.SSD_Out}, IDLE_REC);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send(2'($urandom), 4'($urandom_range(1, 15)), 16'($urandom));
        // Start pulse mid-frame is ignored; then start held high gives back-to-back frames.
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        scramble();
        wait_en();
        @(negedge clk);
        bus.start = 1'b0;
        wait_en();
        @(negedge clk);
        bus.start = 1'b1;
        scramble();
        wait_en();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) wait_en();
        @(negedge clk);
        base = accepts;
        bus.start = 1'b1;
        n = 0;
        while (accepts < base + 2 && n < 3000) begin
            @(negedge clk);
            scramble();
            n++;
        end
        if (n >= 3000) timeout("back_to_back");
        bus.start = 1'b0;
        en_div = 0;
        for (int i = 0; i < 4; i++) send(2'($urandom), 4'($urandom), 16'($urandom));
        wait_idle();
        repeat (40) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
